// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: the CPU load/store port and the debug/loader port share one RAM.
// The CPU has priority, but a starvation limit forces a single debug beat in.
module dmem_arbiter #(
    parameter int AW           = 10,
    parameter int DW           = 10,
    parameter int STARVE_LIMIT = 4,
    parameter int SCW          = 16
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           cpu_req,
    input  logic           cpu_we,
    input  logic [AW-1:0]  cpu_addr,
    input  logic [DW-1:0]  cpu_wdata,
    output logic [DW-1:0]  cpu_rdata,
    output logic           cpu_stall,

    input  logic           dbg_req,
    input  logic           dbg_we,
    input  logic [AW-1:0]  dbg_addr,
    input  logic [DW-1:0]  dbg_wdata,
    output logic [DW-1:0]  dbg_rdata,
    output logic           dbg_done,

    output logic           ram_we,
    output logic [AW-1:0]  ram_addr,
    output logic [DW-1:0]  ram_wdata,
    input  logic [DW-1:0]  ram_rdata,

    output logic [SCW-1:0] stall_cnt
);

    localparam int            CW       = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_LIMIT - 1);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    owner_e         owner_q, owner_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
    logic           conflict;

    // Both ports see the RAM unconditionally; consumers qualify with stall/done.
    assign cpu_rdata = ram_rdata;
    assign dbg_rdata = ram_rdata;
    assign stall_cnt = stall_cnt_q;

    // Forcing the strobes low during reset aborts an in-flight beat before the edge.
    always_comb begin
        // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_req & cpu_we;
        cpu_stall = 1'b0;
        dbg_done  = 1'b0;
        if (owner_q == OWN_DBG) begin
            ram_addr  = dbg_addr;
            ram_wdata = dbg_wdata;
            ram_we    = dbg_req & dbg_we;
            dbg_done  = dbg_req;
            cpu_stall = cpu_req;
        end
        if (!rst_n) begin
            ram_we    = 1'b0;
            cpu_stall = 1'b0;
            dbg_done  = 1'b0;
        end
    end

    // A debug grant lasts exactly one beat, so the DBG owner always hands back.
    always_comb begin
        conflict    = cpu_req & dbg_req;
        owner_d     = OWN_CPU;
        cnt_d       = '0;
        stall_cnt_d = stall_cnt_q;
        if (owner_q == OWN_CPU) begin
            if (dbg_req && (!cpu_req || cnt_q == CNT_LAST)) begin
                owner_d = OWN_DBG;
            end else if (conflict) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (cpu_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + SCW'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= OWN_CPU;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural RAM, an abstract arbitration model and
// a shadow memory; directed scenarios followed by constrained-random traffic.
module tb_dmem_arbiter;

    localparam int AW      = 10;
    localparam int DW      = 10;
    localparam int SL      = 4;
    localparam int SCW     = 16;
    localparam int SCW_SAT = 4;

    logic clk = 1'b0;
    logic rst_n;

    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;

    logic [DW-1:0]  cpu_rdata, dbg_rdata, ram_wdata, ram_rdata;
    logic           cpu_stall, dbg_done, ram_we;
    logic [AW-1:0]  ram_addr;
    logic [SCW-1:0] stall_cnt;

    logic [DW-1:0]      sat_cpu_rdata, sat_dbg_rdata, sat_ram_wdata;
    logic               sat_cpu_stall, sat_dbg_done, sat_ram_we;
    logic [AW-1:0]      sat_ram_addr;
    logic [SCW_SAT-1:0] sat_stall_cnt;

    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    assign ram_rdata = ram_mem[ram_addr];

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .SCW(SCW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stall_cnt(stall_cnt)
    );

    // Narrow stall counter instance sharing the same stimulus, for saturation.
    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .SCW(SCW_SAT)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(sat_cpu_rdata), .cpu_stall(sat_cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(sat_dbg_rdata), .dbg_done(sat_dbg_done),
        .ram_we(sat_ram_we), .ram_addr(sat_ram_addr), .ram_wdata(sat_ram_wdata), .ram_rdata(ram_rdata),
        .stall_cnt(sat_stall_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: whose turn it is, how many conflicts the CPU has won in a row,
    // and how many CPU stall cycles have occurred since reset.
    bit m_dbg_turn;
    int m_wins;
    int m_stalls;

    logic               obs_done, obs_stall, obs_we;
    logic [AW-1:0]      obs_addr;
    logic [DW-1:0]      obs_drd;
    logic [SCW-1:0]     obs_sc;
    logic [SCW_SAT-1:0] obs_sc_sat;

    function automatic logic [AW-1:0] rnd_addr();
        return ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
    endfunction

    task automatic model_reset();
        m_dbg_turn = 1'b0;
        m_wins     = 0;
        m_stalls   = 0;
        cyc        = 0;
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, advance the model.
    task automatic run_cycle(input logic c_req, input logic c_we, input logic [AW-1:0] c_addr,
                             input logic [DW-1:0] c_wd, input logic d_req, input logic d_we,
                             input logic [AW-1:0] d_addr, input logic [DW-1:0] d_wd);
        logic               e_we, e_stall, e_done;
        logic [AW-1:0]      e_addr;
        logic [DW-1:0]      e_wd, e_rd;
        logic [SCW-1:0]     e_sc;
        logic [SCW_SAT-1:0] e_sc_sat;
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
        dbg_req = d_req; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wd;
        if (m_dbg_turn) begin
            e_addr = d_addr; e_wd = d_wd; e_we = d_req & d_we; e_done = d_req; e_stall = c_req;
        end else begin
            e_addr = c_addr; e_wd = c_wd; e_we = c_req & c_we; e_done = 1'b0; e_stall = 1'b0;
        end
        e_rd     = ref_mem[e_addr];
        e_sc     = (m_stalls > 65535) ? '1 : SCW'(m_stalls);
        e_sc_sat = (m_stalls > 15) ? '1 : SCW_SAT'(m_stalls);
        @(negedge clk);
        n_cmp++; if (ram_we !== e_we) begin n_bad++; $display("FAIL ram_we cyc=%0d got=%b exp=%b", cyc, ram_we, e_we); end
        n_cmp++; if (ram_addr !== e_addr) begin n_bad++; $display("FAIL ram_addr cyc=%0d got=%h exp=%h", cyc, ram_addr, e_addr); end
        n_cmp++; if (ram_wdata !== e_wd) begin n_bad++; $display("FAIL ram_wdata cyc=%0d got=%h exp=%h", cyc, ram_wdata, e_wd); end
        n_cmp++; if (cpu_stall !== e_stall) begin n_bad++; $display("FAIL cpu_stall cyc=%0d got=%b exp=%b", cyc, cpu_stall, e_stall); end
        n_cmp++; if (dbg_done !== e_done) begin n_bad++; $display("FAIL dbg_done cyc=%0d got=%b exp=%b", cyc, dbg_done, e_done); end
        n_cmp++; if (cpu_rdata !== e_rd) begin n_bad++; $display("FAIL cpu_rdata cyc=%0d got=%h exp=%h", cyc, cpu_rdata, e_rd); end
        n_cmp++; if (dbg_rdata !== e_rd) begin n_bad++; $display("FAIL dbg_rdata cyc=%0d got=%h exp=%h", cyc, dbg_rdata, e_rd); end
        n_cmp++; if (stall_cnt !== e_sc) begin n_bad++; $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, e_sc); end
        n_cmp++; if (sat_stall_cnt !== e_sc_sat) begin n_bad++; $display("FAIL stall_cnt_sat cyc=%0d got=%h exp=%h", cyc, sat_stall_cnt, e_sc_sat); end
        obs_done = dbg_done; obs_stall = cpu_stall; obs_we = ram_we; obs_addr = ram_addr;
        obs_drd = dbg_rdata; obs_sc = stall_cnt; obs_sc_sat = sat_stall_cnt;
        if (e_we) ref_mem[e_addr] = e_wd;
        if (e_stall) m_stalls++;
        if (m_dbg_turn) begin
            m_dbg_turn = 1'b0; m_wins = 0;
        end else if (d_req && (!c_req || m_wins == SL - 1)) begin
            m_dbg_turn = 1'b1; m_wins = 0;
        end else if (d_req && c_req) begin
            m_wins++;
        end else begin
            m_wins = 0;
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h033; cpu_wdata = 10'h1C3;
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'h044; dbg_wdata = 10'h0F0;
        #3;
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_stall got=%b exp=0", cpu_stall); end
        n_cmp++; if (dbg_done !== 1'b0) begin n_bad++; $display("FAIL reset_dbg_done got=%b exp=0", dbg_done); end
        n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        @(posedge clk); @(posedge clk); #1;
        n_cmp++; if (ram_mem[10'h033] !== ref_mem[10'h033]) begin n_bad++; $display("FAIL reset_no_write got=%h exp=%h", ram_mem[10'h033], ref_mem[10'h033]); end
        rst_n = 1'b1;
        idle_inputs();
        model_reset();
    endtask

    task automatic test_idle_dbg_write();
        do_reset();
        run_cycle(0, 0, '0, '0, 1, 1, 10'h005, 10'h2A5);
        n_cmp++; if (obs_done !== 1'b0) begin n_bad++; $display("FAIL idle_wr_c0_done got=%b exp=0", obs_done); end
        run_cycle(0, 0, '0, '0, 1, 1, 10'h005, 10'h2A5);
        n_cmp++; if (obs_done !== 1'b1) begin n_bad++; $display("FAIL idle_wr_c1_done got=%b exp=1", obs_done); end
        n_cmp++; if (obs_we !== 1'b1) begin n_bad++; $display("FAIL idle_wr_c1_we got=%b exp=1", obs_we); end
        n_cmp++; if (obs_stall !== 1'b0) begin n_bad++; $display("FAIL idle_wr_c1_stall got=%b exp=0", obs_stall); end
        run_cycle(0, 0, '0, '0, 0, 0, '0, '0);
        run_cycle(0, 0, '0, '0, 1, 0, 10'h005, '0);
        run_cycle(0, 0, '0, '0, 1, 0, 10'h005, '0);
        n_cmp++; if (obs_done !== 1'b1) begin n_bad++; $display("FAIL idle_rd_done got=%b exp=1", obs_done); end
        n_cmp++; if (obs_drd !== 10'h2A5) begin n_bad++; $display("FAIL idle_rd_data got=%h exp=2a5", obs_drd); end
    endtask

    task automatic test_starvation();
        logic [5:0] done_map, stall_map;
        logic [SCW-1:0] sc5;
        done_map = '0; stall_map = '0; sc5 = '0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_cycle(1, 1'($urandom), rnd_addr(), DW'($urandom), (i <= 4), 0, 10'h100, '0);
            done_map[i] = obs_done; stall_map[i] = obs_stall;
            if (i == 5) sc5 = obs_sc;
        end
        n_cmp++; if (done_map !== 6'b010000) begin n_bad++; $display("FAIL starve_done_map got=%b exp=010000", done_map); end
        n_cmp++; if (stall_map !== 6'b010000) begin n_bad++; $display("FAIL starve_stall_map got=%b exp=010000", stall_map); end
        n_cmp++; if (sc5 !== SCW'(1)) begin n_bad++; $display("FAIL starve_stall_cnt got=%0d exp=1", sc5); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] done_map;
        logic [SCW-1:0] sc15;
        done_map = '0; sc15 = '0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            run_cycle(1, 0, rnd_addr(), '0, 1, 0, 10'h200, '0);
            done_map[i] = obs_done;
            if (i == 15) sc15 = obs_sc;
        end
        n_cmp++; if (done_map !== 16'h4210) begin n_bad++; $display("FAIL b2b_done_map got=%h exp=4210", done_map); end
        n_cmp++; if ((done_map & (done_map << 1)) !== 16'h0) begin n_bad++; $display("FAIL b2b_consecutive got=%h exp=0", done_map & (done_map << 1)); end
        n_cmp++; if (sc15 !== SCW'(3)) begin n_bad++; $display("FAIL b2b_stall_cnt got=%0d exp=3", sc15); end
    endtask

    task automatic test_stalled_store();
        do_reset();
        run_cycle(1, 1, 10'h010, 10'h155, 0, 0, '0, '0);
        run_cycle(0, 0, '0, '0, 1, 0, 10'h011, '0);
        run_cycle(1, 1, 10'h010, 10'h3FF, 1, 0, 10'h011, '0);
        n_cmp++; if (obs_stall !== 1'b1) begin n_bad++; $display("FAIL store_stalled got=%b exp=1", obs_stall); end
        n_cmp++; if (obs_addr !== 10'h011) begin n_bad++; $display("FAIL store_dbg_addr got=%h exp=011", obs_addr); end
        n_cmp++; if (ram_mem[10'h010] !== 10'h155) begin n_bad++; $display("FAIL store_held got=%h exp=155", ram_mem[10'h010]); end
        run_cycle(1, 1, 10'h010, 10'h3FF, 0, 0, '0, '0);
        n_cmp++; if (obs_stall !== 1'b0) begin n_bad++; $display("FAIL store_retry_stall got=%b exp=0", obs_stall); end
        n_cmp++; if (ram_mem[10'h010] !== 10'h3FF) begin n_bad++; $display("FAIL store_retry got=%h exp=3ff", ram_mem[10'h010]); end
    endtask

    task automatic test_reset_mid_beat();
        logic [4:0] done_map;
        logic [DW-1:0] rd4;
        done_map = '0; rd4 = '0;
        do_reset();
        run_cycle(1, 1, 10'h020, 10'h111, 0, 0, '0, '0);
        run_cycle(0, 0, '0, '0, 1, 1, 10'h020, 10'h0AB);
        cpu_req = 0; dbg_req = 1; dbg_we = 1; dbg_addr = 10'h020; dbg_wdata = 10'h0AB;
        #1;
        n_cmp++; if (ram_we !== 1'b1) begin n_bad++; $display("FAIL midbeat_pre_we got=%b exp=1", ram_we); end
        #1; rst_n = 1'b0; #1;
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL midbeat_we got=%b exp=0", ram_we); end
        n_cmp++; if (dbg_done !== 1'b0) begin n_bad++; $display("FAIL midbeat_done got=%b exp=0", dbg_done); end
        @(posedge clk); #1;
        n_cmp++; if (ram_mem[10'h020] !== 10'h111) begin n_bad++; $display("FAIL midbeat_no_write got=%h exp=111", ram_mem[10'h020]); end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        #1;
        n_cmp++; if ({ram_we, cpu_stall, dbg_done} !== 3'b000) begin n_bad++; $display("FAIL post_reset_strobes got=%b exp=000", {ram_we, cpu_stall, dbg_done}); end
        n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL post_reset_stall_cnt got=%0d exp=0", stall_cnt); end
        n_cmp++; if ({ram_addr, ram_wdata} !== '0) begin n_bad++; $display("FAIL post_reset_bus got=%h exp=0", {ram_addr, ram_wdata}); end
        @(posedge clk); #1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            run_cycle(1, 0, rnd_addr(), '0, 1, 0, 10'h020, '0);
            done_map[i] = obs_done;
            if (i == 4) rd4 = obs_drd;
        end
        n_cmp++; if (done_map !== 5'b10000) begin n_bad++; $display("FAIL post_reset_grant got=%b exp=10000", done_map); end
        n_cmp++; if (rd4 !== 10'h111) begin n_bad++; $display("FAIL post_reset_rdata got=%h exp=111", rd4); end
    endtask

    task automatic test_saturation();
        logic [AW-1:0] a;
        do_reset();
        a = '0;
        for (int i = 0; i < 2 * ((1 << SCW_SAT) + 5); i++) begin
            if (i % 2 == 0) a = rnd_addr();
            run_cycle((i % 2 == 1), 0, rnd_addr(), '0, 1, 0, a, '0);
        end
        run_cycle(0, 0, '0, '0, 0, 0, '0, '0);
        n_cmp++; if (obs_sc_sat !== 4'hF) begin n_bad++; $display("FAIL sat_stall_cnt got=%h exp=f", obs_sc_sat); end
        n_cmp++; if (obs_sc !== SCW'(21)) begin n_bad++; $display("FAIL wide_stall_cnt got=%0d exp=21", obs_sc); end
    endtask

    task automatic test_random();
        logic          d_pend, d_we_r;
        logic [AW-1:0] d_addr_r;
        logic [DW-1:0] d_wd_r;
        do_reset();
        d_pend = 0; d_we_r = 0; d_addr_r = '0; d_wd_r = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_we_r = 1'($urandom); d_addr_r = rnd_addr(); d_wd_r = DW'($urandom);
            end else if (d_pend && $urandom_range(0, 15) == 0) begin
                d_pend = 0;
            end
            run_cycle(($urandom_range(0, 3) != 0), 1'($urandom), rnd_addr(), DW'($urandom),
                      d_pend, d_we_r, d_addr_r, d_wd_r);
            if (obs_done) d_pend = 0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = DW'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        idle_inputs();
        model_reset();
        test_reset();
        test_idle_dbg_write();
        test_starvation();
        test_back_to_back();
        test_stalled_store();
        test_reset_mid_beat();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data RAM (async read, sync write, 10-bit address/data) between the CPU load/store port and a debug/loader port.
- CPU has default priority.
- A starvation counter forces one debug beat after STARVE_LIMIT consecutive CPU-won conflict cycles.
- The CPU is stalled for that cycle, and the block counts total CPU stall cycles for bring-up.

Parameters:
AW, 10, RAM address width
DW, 10, RAM data width
STARVE_LIMIT, 4, consecutive conflict cycles the CPU may win before debug is forced in (>=1)
SCW, 16, stall-counter width

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU load/store this cycle
cpu_we  input  1  CPU store
cpu_addr  input  AW  CPU effective address
cpu_wdata  input  DW  CPU store data
cpu_rdata  output  DW  RAM read data to CPU (valid when not stalled)
cpu_stall  output  1  CPU must hold PC and suppress writeback this cycle
dbg_req  input  1  debug access request, held until dbg_done
dbg_we  input  1  debug write
dbg_addr  input  AW  debug address
dbg_wdata  input  DW  debug write data
dbg_rdata  output  DW  RAM read data to debug port (valid when dbg_done)
dbg_done  output  1  debug beat performed this cycle
ram_we  output  1  RAM write enable
ram_addr  output  AW  RAM address
ram_wdata  output  DW  RAM write data
ram_rdata  input  DW  RAM async read data
stall_cnt  output  SCW  saturating count of cycles with cpu_stall=1

Behaviour:
- State:
  - owner register (CPU=0 / DBG=1)
  - conflict counter cnt, width clog2(STARVE_LIMIT)+1
  - stall_cnt
- Reset (rst_n low, async) and every output while rst_n is low:
  - owner=CPU, cnt=0, stall_cnt=0
  - ram_we=0, cpu_stall=0, dbg_done=0
  - Reset mid-beat aborts the beat; no write occurs.
- owner=CPU cycle:
  - ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_req&cpu_we
  - cpu_stall=0, dbg_done=0
- owner=DBG cycle:
  - ram_addr=dbg_addr, ram_wdata=dbg_wdata, ram_we=dbg_req&dbg_we
  - dbg_done=dbg_req
  - cpu_stall=cpu_req
- cpu_rdata and dbg_rdata are both driven from ram_rdata unconditionally. Consumers qualify with cpu_stall/dbg_done.
- Next-state from owner=CPU:
  - owner_next=DBG iff dbg_req & (!cpu_req | cnt==STARVE_LIMIT-1)
  - cnt_next = dbg_req&cpu_req&(owner_next==CPU) ? cnt+1 : 0
- Next-state from owner=DBG:
  - owner_next=CPU always (exactly one beat per grant), cnt_next=0.
  - Debug cannot win back-to-back. If dbg_req stays high after dbg_done, it is a new request and re-arbitrates from owner=CPU.
- Grant latency:
  - Idle CPU: 1 cycle from dbg_req rise to dbg_done.
  - Continuously busy CPU: STARVE_LIMIT CPU cycles, then the DBG beat.
- dbg_req dropped during the DBG cycle: no write, no dbg_done, CPU still stalled that cycle (owner already committed).
- stall_cnt increments on each cycle with cpu_stall=1 and saturates at all-ones.
- Simultaneous cpu_req and dbg_req with cnt below the limit: CPU wins, no stall.
- The same address accessed by both sides in consecutive cycles is handled by RAM ordering: the write lands at the clock edge, and the next cycle's read sees it.

Test Plan:
- Idle CPU, dbg write addr 0x005 data 0x2A5 at cycle 0 -> dbg_done=1, ram_we=1 in cycle 1, cpu_stall=0; dbg read 0x005 next request -> dbg_rdata=0x2A5.
- cpu_req=1 every cycle, dbg_req rises cycle 0, STARVE_LIMIT=4 -> CPU owns cycles 0-3; cycle 4 owner=DBG with cpu_stall=1, dbg_done=1; cycle 5 CPU again, cnt=0, stall_cnt=1.
- dbg_req held high 3 beats with continuous cpu_req -> dbg_done at cycles 4, 9, 14; never two consecutive DBG cycles; stall_cnt=3.
- CPU store 0x3FF to 0x010 while stalled (owner=DBG, dbg read of 0x011) -> RAM 0x010 unchanged that cycle; the CPU retry next cycle writes 0x3FF.
- rst_n pulled low in the middle of a DBG write cycle -> ram_we=0 immediately, no write to RAM; after release, owner=CPU, cnt=0, stall_cnt=0, outputs zero.
- Force 2^SCW+5 stall cycles with SCW=4 -> stall_cnt holds 0xF.
